// File: rtl/matrix_mult_stream.sv
// matrix_mult_stream: streamed NxN multiply C = A x B, one MAC per cycle, valid/ready on both sides.
// Define MM_SIGNED_EN for two's complement operands and results.
module matrix_mult_stream #(
    parameter int M  = 2,
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DW-1:0]       a_in,
    input  logic [DW-1:0]       b_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*DW+M-1:0]   c_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                c_last,
    output logic                busy
);
    localparam int N  = 2**M;
    localparam int AW = 2*DW+M;

    typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   a_mem [N*N];
    logic [DW-1:0]   b_mem [N*N];
    logic [2*M-1:0]  ld_idx;
    logic [M-1:0]    i, j, k;
    logic [AW-1:0]   acc, prod, a_x, b_x;
    logic            last_el;

    assign last_el = &{i, j};

    // Operands widened to the accumulator width so the product can never wrap.
`ifdef MM_SIGNED_EN
    assign a_x = AW'($signed(a_mem[{i, k}]));
    assign b_x = AW'($signed(b_mem[{k, j}]));
`else
    assign a_x = AW'(a_mem[{i, k}]);
    assign b_x = AW'(b_mem[{k, j}]);
`endif
    assign prod = a_x * b_x;

    always_ff @(posedge clk) begin
        if (reset)
            state <= LOAD;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = !reset && state == LOAD;
        out_valid = !reset && state == OUT;
        busy      = !reset && state != LOAD;
        c_last    = out_valid && last_el;
        c_out     = reset ? '0 : acc;
        case (state)
            LOAD:    state_nx = (in_valid && &ld_idx) ? MAC : LOAD;
            MAC:     state_nx = &k ? OUT : MAC;
            OUT:     state_nx = !out_ready ? OUT : last_el ? LOAD : MAC;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && state == LOAD && in_valid) begin
            a_mem[ld_idx] <= a_in;
            b_mem[ld_idx] <= b_in;
        end
    end

    // Indices wrap naturally: ld_idx after the last load and i/j after the last result return to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_idx <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) ld_idx <= ld_idx + 1'b1;
                MAC: begin
                    acc <= acc + prod;
                    k   <= k + 1'b1;
                end
                OUT: if (out_ready) begin
                    acc <= '0;
                    j   <= j + 1'b1;
                    if (&j) i <= i + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mult_stream.sv
// tb_matrix_mult_stream: directed/random bench for matrix_mult_stream against a plain-arithmetic matrix product.
module tb_matrix_mult_stream;
    localparam int N  = 4;
    localparam int NN = 16;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    a_in = '0;
    logic [7:0]    b_in = '0;
    logic          in_ready, out_valid, c_last, busy;
    logic [AW-1:0] c_out;

    logic [7:0]    a_m [NN];
    logic [7:0]    b_m [NN];
    logic [AW-1:0] exp_c [NN];
    int            tests = 0;
    int            fails = 0;
    int            first;

    matrix_mult_stream dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(in_ready), .c_out(c_out), .out_valid(out_valid), .out_ready(out_ready),
        .c_last(c_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int val(input logic [7:0] x);
`ifdef MM_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    task automatic model();
        int s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int q = 0; q < N; q++) s += val(a_m[r*N+q]) * val(b_m[q*N+c]);
                exp_c[r*N+c] = AW'(s);
            end
    endtask

    task automatic load_all(input bit gaps);
        int idx = 0;
        int cyc = 0;
        model();
        while (idx < NN && cyc < 500) begin
            @(negedge clk);
            cyc++;
            chk("no_out_during_load", {31'b0, out_valid}, 0);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            a_in = in_valid ? a_m[idx] : 8'($urandom);
            b_in = in_valid ? b_m[idx] : 8'($urandom);
            if (in_valid && in_ready) idx++;
        end
        chk("load_done", idx, NN);
    endtask

    // mode 0: always ready, 1: random ready, 2: ten-cycle stall on element 5
    task automatic collect(input int mode, input bit noise, output int first_v);
        int r = 0;
        int cyc = 0;
        int stall = 0;
        int last_v = 0;
        first_v = -1;
        out_ready = (mode == 0);
        while (r < NN && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            chk("in_ready_low", {31'b0, in_ready}, 0);
            chk("busy_high", {31'b0, busy}, 1);
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (mode == 0 && r > 0) chk("result_spacing", cyc - last_v, N + 1);
                last_v = cyc;
                chk($sformatf("c_out[%0d]", r), 32'(c_out), 32'(exp_c[r]));
                chk($sformatf("c_last[%0d]", r), {31'b0, c_last}, {31'b0, r == NN - 1});
                out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(r == 5 && stall < 10);
                if (mode == 2 && !out_ready) stall++;
                if (out_ready) r++;
            end
        end
        in_valid = 1'b0;
        chk("all_results", r, NN);
        if (mode == 2) chk("stall_cycles", stall, 10);
    endtask

    task automatic fill_identity();
        for (int n = 0; n < NN; n++) begin
            a_m[n] = (n / N == n % N) ? 8'd1 : 8'd0;
            b_m[n] = 8'(n);
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < NN; n++) begin
            a_m[n] = 8'($urandom);
            b_m[n] = 8'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_c_last"}, {31'b0, c_last}, 0);
        chk({tag, "_c_out"}, 32'(c_out), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'b0, in_ready}, 1);

        // identity x index matrix, latency and spacing
        fill_identity();
        load_all(1'b0);
        collect(0, 1'b0, first);
        chk("latency_edges", first - 1, N);

        // all-ones bytes: maximum magnitude products
        for (int n = 0; n < NN; n++) begin
            a_m[n] = 8'hFF;
            b_m[n] = 8'hFF;
        end
        load_all(1'b1);
        collect(1, 1'b0, first);

        // ten-cycle backpressure stall
        fill_random();
        load_all(1'b1);
        collect(2, 1'b0, first);

        // reset after a partial load, then a full reload
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in = 8'($urandom);
            b_in = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        check_reset_outputs("reset_mid_load");
        @(negedge clk);
        reset = 1'b0;
        fill_identity();
        load_all(1'b0);
        collect(0, 1'b0, first);

        // reset while a result is pending
        fill_random();
        load_all(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("pending_out_valid", {31'b0, out_valid}, 1);
        reset = 1'b1;
        check_reset_outputs("reset_mid_out");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset2", {31'b0, in_ready}, 1);

        // -1 x 2 sums: sign handling
        for (int n = 0; n < NN; n++) begin
            a_m[n] = 8'hFF;
            b_m[n] = 8'h02;
        end
        load_all(1'b0);
        collect(1, 1'b0, first);

        // operand noise during MAC/OUT, then fresh data
        fill_random();
        load_all(1'b1);
        collect(1, 1'b1, first);
        fill_random();
        load_all(1'b0);
        collect(0, 1'b0, first);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
